sync_fifo_prog: RTL and testbench

// - Parametrised synchronous FIFO; next generation of the team's FIFO DUT.
// - Adds programmable almost-full/almost-empty thresholds, occupancy count output,
//   non-power-of-two depth, and a selectable first-word-fall-through (FWFT) read mode.
// - Sits between a producer and a consumer in one clock domain.
// - Drives the same flag set our FIFO monitor/scoreboard already samples.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_prog.sv | 130 +++++++++++++
 tb/tb_sync_fifo_prog.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable synchronous FIFO and its bench.
package fifo_pkg;

   // Status bits in the order the FIFO monitor samples them
   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
      logic wr_ack;
      logic overflow;
      logic underflow;
   } fifo_flags_t;

   // Like $clog2 but never returns 0, so a vector declared with it is always legal
   function automatic int clog2_safe(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write port, combinational read port.
module fifo_mem #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are never cleared; the pointer/count registers decide what is valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, occupancy
// count, arbitrary depth and optional first-word-fall-through read mode.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int FWFT  = 0,
   localparam int ADDR_W = clog2_safe(DEPTH),
   localparam int CNT_W  = clog2_safe(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] data_in,
   input  logic [CNT_W-1:0] af_thresh,
   input  logic [CNT_W-1:0] ae_thresh,
   output logic [WIDTH-1:0] data_out,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almostfull,
   output logic             almostempty,
   output logic             wr_ack,
   output logic             overflow,
   output logic             underflow
);

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              wr_acc;
   logic              rd_acc;
   logic              wr_ack_q;
   logic              overflow_q;
   logic              underflow_q;
   logic [WIDTH-1:0]  mem_rd_data;
   fifo_flags_t       flags;

   // Wrap explicitly at DEPTH-1 so non-power-of-two depths never touch unused slots
   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
      return (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
   endfunction

   always_comb begin
      flags             = '0;
      flags.full        = (count_q == CNT_W'(DEPTH));
      flags.empty       = (count_q == '0);
      flags.almostfull  = (af_thresh != '0) && (count_q >= af_thresh);
      flags.almostempty = (count_q <= ae_thresh);
      flags.wr_ack      = wr_ack_q;
      flags.overflow    = overflow_q;
      flags.underflow   = underflow_q;
   end

   // A write into a full FIFO is still taken when a read frees a slot on the same edge
   always_comb begin
      rd_acc = rd_en && !flags.empty;
      wr_acc = wr_en && (!flags.full || rd_acc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (rd_acc) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         wr_ack_q    <= wr_acc;
         overflow_q  <= wr_en && !wr_acc;
         underflow_q <= rd_en && !rd_acc;
      end
   end

   fifo_mem #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (data_in),
      .rd_addr (rd_ptr),
      .rd_data (mem_rd_data)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         assign data_out = flags.empty ? '0 : mem_rd_data;
      end else begin : g_registered
         logic [WIDTH-1:0] data_q;

         // Registered mode holds the last popped word until the next accepted read
         always_ff @(posedge clk) begin
            if (rst) begin
               data_q <= '0;
            end else if (rd_acc) begin
               data_q <= mem_rd_data;
            end
         end

         assign data_out = data_q;
      end
   endgenerate

   assign count       = count_q;
   assign full        = flags.full;
   assign empty       = flags.empty;
   assign almostfull  = flags.almostfull;
   assign almostempty = flags.almostempty;
   assign wr_ack      = flags.wr_ack;
   assign overflow    = flags.overflow;
   assign underflow   = flags.underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a registered-read and an FWFT instance share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_prog;
   import fifo_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 6;
   localparam int CNT_W = 3;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] data_in;
   logic [CNT_W-1:0] af_thresh;
   logic [CNT_W-1:0] ae_thresh;

   logic [WIDTH-1:0] dout0, dout1;
   logic [CNT_W-1:0] count0, count1;
   logic full0, empty0, af0, ae0, ack0, ovf0, unf0;
   logic full1, empty1, af1, ae1, ack1, ovf1, unf1;
   fifo_flags_t got0, got1;

   int n_cmp;
   int n_err;

   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] m_dout;
   bit m_ack, m_ovf, m_unf;

   sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_reg (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(dout0), .count(count0),
      .full(full0), .empty(empty0), .almostfull(af0), .almostempty(ae0),
      .wr_ack(ack0), .overflow(ovf0), .underflow(unf0)
   );

   sync_fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .data_out(dout1), .count(count1),
      .full(full1), .empty(empty1), .almostfull(af1), .almostempty(ae1),
      .wr_ack(ack1), .overflow(ovf1), .underflow(unf1)
   );

   assign got0 = {full0, empty0, af0, ae0, ack0, ovf0, unf0};
   assign got1 = {full1, empty1, af1, ae1, ack1, ovf1, unf1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag set the model expects from its current occupancy and the live thresholds
   function automatic fifo_flags_t exp_flags();
      fifo_flags_t f;
      int n;
      n = q.size();
      f.full        = (n == DEPTH);
      f.empty       = (n == 0);
      f.almostfull  = (af_thresh != 0) && (n >= int'(af_thresh));
      f.almostempty = (n <= int'(ae_thresh));
      f.wr_ack      = m_ack;
      f.overflow    = m_ovf;
      f.underflow   = m_unf;
      return f;
   endfunction

   // One clock of stimulus; the model is advanced just after the edge
   task automatic cycle(input bit r, input bit w, input bit rd, input logic [WIDTH-1:0] d);
      rst     = r;
      wr_en   = w;
      rd_en   = rd;
      data_in = d;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         m_dout = '0;
         m_ack  = 0;
         m_ovf  = 0;
         m_unf  = 0;
      end else begin
         bit rok, wok;
         rok = rd && (q.size() != 0);
         wok = w && ((q.size() < DEPTH) || rok);
         if (rok) m_dout = q.pop_front();
         if (wok) q.push_back(d);
         m_ack = wok;
         m_ovf = w && !wok;
         m_unf = rd && !rok;
      end
      rst   = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset();
      af_thresh = 3'd5;
      ae_thresh = 3'd1;
      cycle(1, 0, 0, '0);
      n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("[TB] FAIL reset_count got %0d want 0", count0); end
      n_cmp++; if (got0 !== 7'b0101000) begin n_err++; $display("[TB] FAIL reset_flags got %b want 0101000", got0); end
      n_cmp++; if (dout0 !== 16'h0) begin n_err++; $display("[TB] FAIL reset_dout got %h want 0000", dout0); end
      n_cmp++; if (dout1 !== 16'h0) begin n_err++; $display("[TB] FAIL reset_dout_fwft got %h want 0000", dout1); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(0, 1, 0, 16'hA0 + 16'(i));
         n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("[TB] FAIL fill_ack[%0d] got %b want 1", i, ack0); end
         n_cmp++; if (count0 !== 3'(i + 1)) begin n_err++; $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count0, i + 1); end
         n_cmp++; if (af0 !== (i + 1 >= 5)) begin n_err++; $display("[TB] FAIL fill_af[%0d] got %b want %b", i, af0, (i + 1 >= 5)); end
         n_cmp++; if (full0 !== (i == DEPTH - 1)) begin n_err++; $display("[TB] FAIL fill_full[%0d] got %b want %b", i, full0, (i == DEPTH - 1)); end
         n_cmp++; if (dout1 !== 16'hA0) begin n_err++; $display("[TB] FAIL fill_fwft_head[%0d] got %h want 00a0", i, dout1); end
      end
   endtask

   task automatic test_overflow();
      cycle(0, 1, 0, 16'hEE);
      n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("[TB] FAIL ovf_flag got %b want 1", ovf0); end
      n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("[TB] FAIL ovf_ack got %b want 0", ack0); end
      n_cmp++; if (count0 !== 3'd6) begin n_err++; $display("[TB] FAIL ovf_count got %0d want 6", count0); end
   endtask

   task automatic test_full_rw();
      logic [WIDTH-1:0] want;
      cycle(0, 1, 1, 16'hB0);
      n_cmp++; if (dout0 !== 16'hA0) begin n_err++; $display("[TB] FAIL fullrw_dout got %h want 00a0", dout0); end
      n_cmp++; if (count0 !== 3'd6) begin n_err++; $display("[TB] FAIL fullrw_count got %0d want 6", count0); end
      n_cmp++; if (ack0 !== 1'b1 || ovf0 !== 1'b0) begin n_err++; $display("[TB] FAIL fullrw_ack got ack=%b ovf=%b want ack=1 ovf=0", ack0, ovf0); end
      for (int i = 0; i < DEPTH; i++) begin
         want = (i < 5) ? 16'hA1 + 16'(i) : 16'hB0;
         cycle(0, 0, 1, '0);
         n_cmp++; if (dout0 !== want) begin n_err++; $display("[TB] FAIL wrap_drain[%0d] got %h want %h", i, dout0, want); end
      end
      n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_empty got %b want 1", empty0); end
   endtask

   task automatic test_underflow();
      cycle(1, 0, 0, '0);
      cycle(0, 0, 1, '0);
      n_cmp++; if (unf0 !== 1'b1) begin n_err++; $display("[TB] FAIL unf_flag got %b want 1", unf0); end
      n_cmp++; if (dout0 !== 16'h0) begin n_err++; $display("[TB] FAIL unf_dout got %h want 0000", dout0); end
      n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("[TB] FAIL unf_count got %0d want 0", count0); end
      cycle(0, 1, 1, 16'h11);
      n_cmp++; if (unf0 !== 1'b1 || ack0 !== 1'b1) begin n_err++; $display("[TB] FAIL unf_both got unf=%b ack=%b want 1 1", unf0, ack0); end
      n_cmp++; if (count0 !== 3'd1) begin n_err++; $display("[TB] FAIL unf_both_count got %0d want 1", count0); end
      n_cmp++; if (dout1 !== 16'h11) begin n_err++; $display("[TB] FAIL unf_both_fwft got %h want 0011", dout1); end
   endtask

   task automatic test_fwft();
      cycle(1, 0, 0, '0);
      cycle(0, 1, 0, 16'h55);
      n_cmp++; if (dout1 !== 16'h55) begin n_err++; $display("[TB] FAIL fwft_first got %h want 0055", dout1); end
      cycle(0, 1, 0, 16'h66);
      n_cmp++; if (dout1 !== 16'h55) begin n_err++; $display("[TB] FAIL fwft_hold got %h want 0055", dout1); end
      cycle(0, 0, 1, '0);
      n_cmp++; if (dout1 !== 16'h66) begin n_err++; $display("[TB] FAIL fwft_pop got %h want 0066", dout1); end
      n_cmp++; if (dout0 !== 16'h55) begin n_err++; $display("[TB] FAIL fwft_regpath got %h want 0055", dout0); end
   endtask

   task automatic test_reset_mid();
      cycle(1, 0, 0, '0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'($urandom));
      n_cmp++; if (count0 !== 3'd4) begin n_err++; $display("[TB] FAIL mid_pre_count got %0d want 4", count0); end
      cycle(1, 1, 1, 16'($urandom));
      n_cmp++; if (count0 !== 3'd0) begin n_err++; $display("[TB] FAIL mid_count got %0d want 0", count0); end
      n_cmp++; if (got0 !== 7'b0101000) begin n_err++; $display("[TB] FAIL mid_flags got %b want 0101000", got0); end
      cycle(0, 1, 0, 16'h77);
      n_cmp++; if (dout1 !== 16'h77) begin n_err++; $display("[TB] FAIL mid_fwft_new got %h want 0077", dout1); end
      cycle(0, 0, 1, '0);
      n_cmp++; if (dout0 !== 16'h77) begin n_err++; $display("[TB] FAIL mid_read_new got %h want 0077", dout0); end
   endtask

   task automatic test_random();
      fifo_flags_t ef;
      logic [WIDTH-1:0] head;
      int wr_pct, rd_pct;
      cycle(1, 0, 0, '0);
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) begin
            af_thresh = 3'($urandom_range(0, DEPTH));
            ae_thresh = 3'($urandom_range(0, DEPTH));
         end
         wr_pct = (i < 200) ? 75 : (i < 400) ? 30 : 55;
         rd_pct = 100 - wr_pct;
         cycle(0, ($urandom % 100) < wr_pct, ($urandom % 100) < rd_pct, 16'($urandom));
         ef   = exp_flags();
         head = (q.size() != 0) ? q[0] : '0;
         n_cmp++; if (count0 !== 3'(q.size())) begin n_err++; $display("[TB] FAIL rnd_count[%0d] got %0d want %0d", i, count0, q.size()); end
         n_cmp++; if (got0 !== ef) begin n_err++; $display("[TB] FAIL rnd_flags[%0d] got %b want %b", i, got0, ef); end
         n_cmp++; if (dout0 !== m_dout) begin n_err++; $display("[TB] FAIL rnd_dout[%0d] got %h want %h", i, dout0, m_dout); end
         n_cmp++; if (count1 !== 3'(q.size())) begin n_err++; $display("[TB] FAIL rnd_count_fwft[%0d] got %0d want %0d", i, count1, q.size()); end
         n_cmp++; if (got1 !== ef) begin n_err++; $display("[TB] FAIL rnd_flags_fwft[%0d] got %b want %b", i, got1, ef); end
         n_cmp++; if (dout1 !== head) begin n_err++; $display("[TB] FAIL rnd_dout_fwft[%0d] got %h want %h", i, dout1, head); end
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst       = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      data_in   = '0;
      af_thresh = 3'd5;
      ae_thresh = 3'd1;
      m_dout    = '0;
      m_ack     = 0;
      m_ovf     = 0;
      m_unf     = 0;
      test_reset();
      test_fill();
      test_overflow();
      test_full_rw();
      test_underflow();
      test_fwft();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
